// File: rtl/freq_count.sv
// Symbol frequency counter feeding the Huffman sorter: counts legal symbols per block, then
// presents the packed {symbol, count} vector until the sorter acknowledges. Optional macro: FREQ_BAD_SYM_CNT_EN.
module freq_count #(
    parameter int NSYM = 10,
    parameter int SW = 4,
    parameter int CW = 9,
    localparam int FW = NSYM * (SW + CW)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          sym_valid,
    output logic          sym_ready,
    input  logic [SW-1:0] SYM_IN,
    input  logic          sym_last,
    output logic          sort_begin,
    input  logic          sort_over,
    output logic [FW-1:0] FREQUENT_OUT,
`ifdef FREQ_BAD_SYM_CNT_EN
    output logic [7:0]    bad_cnt,
`endif
    output logic          busy
);

    localparam int EW = SW + CW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        PACK  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt [NSYM];
    logic [FW-1:0] pack_vec;
    logic          accept;
    logic          release_blk;

    function automatic logic [CW-1:0] sat_inc_cnt(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [7:0] sat_inc_bad(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign accept      = sym_valid && sym_ready;
    assign release_blk = (state == DONE) && sort_over;
    assign busy        = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sym_ready  = 1'b0;
        sort_begin = 1'b0;
        case (state)
            IDLE, COUNT: begin
                sym_ready = 1'b1;
                if (sym_valid) begin
                    state_nxt = sym_last ? PACK : COUNT;
                end
            end
            PACK: state_nxt = DONE;
            DONE: begin
                sort_begin = 1'b1;
                if (sort_over) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Count stage: illegal codes never match a counter index, so they drop out here
    always_ff @(posedge CLK) begin
        if (RST || release_blk) begin
            for (int i = 0; i < NSYM; i++) begin
                cnt[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NSYM; i++) begin
                if (SYM_IN == SW'(i)) begin
                    cnt[i] <= sat_inc_cnt(cnt[i]);
                end
            end
        end
    end

`ifdef FREQ_BAD_SYM_CNT_EN
    logic sym_bad;
    assign sym_bad = (int'(SYM_IN) >= NSYM);

    always_ff @(posedge CLK) begin
        if (RST || release_blk) begin
            bad_cnt <= '0;
        end else if (accept && sym_bad) begin
            bad_cnt <= sat_inc_bad(bad_cnt);
        end
    end
`endif

    always_comb begin
        pack_vec = '0;
        for (int i = 0; i < NSYM; i++) begin
            pack_vec[i*EW +: EW] = {i[SW-1:0], cnt[i]};
        end
    end

    // Pack stage: output keeps its last value after release, only reset zeroes it
    always_ff @(posedge CLK) begin
        if (RST) begin
            FREQUENT_OUT <= '0;
        end else if (state == PACK) begin
            FREQUENT_OUT <= pack_vec;
        end
    end

endmodule

// File: tb/tb_freq_count.sv
// Directed bench for freq_count: per-scenario tasks with inline checks against hand-built count tables.
module tb_freq_count;

    logic         CLK;
    logic         RST;
    logic         sym_valid;
    logic         sym_ready;
    logic [3:0]   SYM_IN;
    logic         sym_last;
    logic         sort_begin;
    logic         sort_over;
    logic [129:0] FREQUENT_OUT;
    logic         busy;
`ifdef FREQ_BAD_SYM_CNT_EN
    logic [7:0]   bad_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt [10];

    freq_count dut (
        .CLK          (CLK),
        .RST          (RST),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .SYM_IN       (SYM_IN),
        .sym_last     (sym_last),
        .sort_begin   (sort_begin),
        .sort_over    (sort_over),
        .FREQUENT_OUT (FREQUENT_OUT),
`ifdef FREQ_BAD_SYM_CNT_EN
        .bad_cnt      (bad_cnt),
`endif
        .busy         (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [129:0] exp_vec();
        logic [129:0] v;
        v = '0;
        for (int i = 0; i < 10; i++) begin
            v[13*i +: 13] = {i[3:0], exp_cnt[i][8:0]};
        end
        return v;
    endfunction

    task automatic clear_exp();
        for (int i = 0; i < 10; i++) exp_cnt[i] = 0;
    endtask

    // Present one symbol, wait for the accepting edge, return at edge+1.
    task automatic send(input logic [3:0] s, input logic l);
        sym_valid = 1'b1;
        SYM_IN    = s;
        sym_last  = l;
        @(posedge CLK);
        #1;
        sym_valid = 1'b0;
        sym_last  = 1'b0;
    endtask

    task automatic pulse_sort_over();
        sort_over = 1'b1;
        @(posedge CLK);
        #1;
        sort_over = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        n_cmp++; if (sym_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", sym_ready); end
        n_cmp++; if (sort_begin !== 1'b0) begin n_bad++; $display("FAIL reset_begin: got %b want 0", sort_begin); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (FREQUENT_OUT !== 130'd0) begin n_bad++; $display("FAIL reset_vec: got %h want 0", FREQUENT_OUT); end
    endtask

    task automatic test_basic_count();
        clear_exp();
        exp_cnt[3] = 3; exp_cnt[7] = 1; exp_cnt[0] = 1;
        send(4'd3, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_count: got %b want 1", busy); end
        send(4'd3, 1'b0);
        send(4'd7, 1'b0);
        send(4'd0, 1'b0);
        send(4'd3, 1'b1);
        n_cmp++; if (sort_begin !== 1'b0) begin n_bad++; $display("FAIL basic_begin_early: got %b want 0", sort_begin); end
        n_cmp++; if (sym_ready !== 1'b0) begin n_bad++; $display("FAIL basic_ready_pack: got %b want 0", sym_ready); end
        @(posedge CLK);
        #1;
        n_cmp++; if (sort_begin !== 1'b1) begin n_bad++; $display("FAIL basic_begin: got %b want 1", sort_begin); end
        n_cmp++; if (FREQUENT_OUT !== exp_vec()) begin n_bad++; $display("FAIL basic_vec: got %h want %h", FREQUENT_OUT, exp_vec()); end
    endtask

    task automatic test_handshake_hold();
        for (int c = 0; c < 20; c++) begin
            @(posedge CLK);
            #1;
            n_cmp++; if (sort_begin !== 1'b1) begin n_bad++; $display("FAIL hold_begin[%0d]: got %b want 1", c, sort_begin); end
            n_cmp++; if (sym_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready[%0d]: got %b want 0", c, sym_ready); end
            n_cmp++; if (FREQUENT_OUT !== exp_vec()) begin n_bad++; $display("FAIL hold_vec[%0d]: got %h want %h", c, FREQUENT_OUT, exp_vec()); end
        end
        pulse_sort_over();
        n_cmp++; if (sort_begin !== 1'b0) begin n_bad++; $display("FAIL release_begin: got %b want 0", sort_begin); end
        n_cmp++; if (sym_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %b want 1", sym_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL release_busy: got %b want 0", busy); end
        n_cmp++; if (FREQUENT_OUT !== exp_vec()) begin n_bad++; $display("FAIL release_vec_held: got %h want %h", FREQUENT_OUT, exp_vec()); end
    endtask

    task automatic test_saturation();
        clear_exp();
        exp_cnt[5] = 511; exp_cnt[1] = 1;
        for (int k = 0; k < 600; k++) send(4'd5, 1'b0);
        send(4'd1, 1'b1);
        @(posedge CLK);
        #1;
        n_cmp++; if (sort_begin !== 1'b1) begin n_bad++; $display("FAIL sat_begin: got %b want 1", sort_begin); end
        n_cmp++; if (FREQUENT_OUT !== exp_vec()) begin n_bad++; $display("FAIL sat_vec: got %h want %h", FREQUENT_OUT, exp_vec()); end
        pulse_sort_over();
    endtask

    task automatic test_illegal();
        clear_exp();
        exp_cnt[2] = 1;
        send(4'd12, 1'b0);
        send(4'd15, 1'b0);
        send(4'd2, 1'b1);
        @(posedge CLK);
        #1;
        n_cmp++; if (sort_begin !== 1'b1) begin n_bad++; $display("FAIL illegal_begin: got %b want 1", sort_begin); end
        n_cmp++; if (FREQUENT_OUT !== exp_vec()) begin n_bad++; $display("FAIL illegal_vec: got %h want %h", FREQUENT_OUT, exp_vec()); end
`ifdef FREQ_BAD_SYM_CNT_EN
        n_cmp++; if (bad_cnt !== 8'd2) begin n_bad++; $display("FAIL illegal_bad_cnt: got %0d want 2", bad_cnt); end
`endif
        pulse_sort_over();
`ifdef FREQ_BAD_SYM_CNT_EN
        n_cmp++; if (bad_cnt !== 8'd0) begin n_bad++; $display("FAIL bad_cnt_clear: got %0d want 0", bad_cnt); end
`endif
        // Lone illegal symbol with last still closes the block, with all counts zero.
        clear_exp();
        send(4'd11, 1'b1);
        @(posedge CLK);
        #1;
        n_cmp++; if (sort_begin !== 1'b1) begin n_bad++; $display("FAIL lone_illegal_begin: got %b want 1", sort_begin); end
        n_cmp++; if (FREQUENT_OUT !== exp_vec()) begin n_bad++; $display("FAIL lone_illegal_vec: got %h want %h", FREQUENT_OUT, exp_vec()); end
        pulse_sort_over();
    endtask

    task automatic test_single_transfer();
        clear_exp();
        exp_cnt[9] = 1;
        send(4'd9, 1'b1);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
        n_cmp++; if (sym_ready !== 1'b0) begin n_bad++; $display("FAIL single_ready_pack: got %b want 0", sym_ready); end
        @(posedge CLK);
        #1;
        n_cmp++; if (sort_begin !== 1'b1) begin n_bad++; $display("FAIL single_begin: got %b want 1", sort_begin); end
        n_cmp++; if (FREQUENT_OUT !== exp_vec()) begin n_bad++; $display("FAIL single_vec: got %h want %h", FREQUENT_OUT, exp_vec()); end
        pulse_sort_over();
    endtask

    task automatic test_sort_over_ignored();
        clear_exp();
        exp_cnt[8] = 2;
        sort_over = 1'b1;
        send(4'd8, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ignore_busy: got %b want 1", busy); end
        send(4'd8, 1'b1);
        sort_over = 1'b0;
        @(posedge CLK);
        #1;
        n_cmp++; if (sort_begin !== 1'b1) begin n_bad++; $display("FAIL ignore_begin: got %b want 1", sort_begin); end
        n_cmp++; if (FREQUENT_OUT !== exp_vec()) begin n_bad++; $display("FAIL ignore_vec: got %h want %h", FREQUENT_OUT, exp_vec()); end
        pulse_sort_over();
    endtask

    task automatic test_reset_mid();
        send(4'd1, 1'b0);
        send(4'd2, 1'b0);
        send(4'd4, 1'b0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (sort_begin !== 1'b0) begin n_bad++; $display("FAIL rstmid_begin: got %b want 0", sort_begin); end
        n_cmp++; if (FREQUENT_OUT !== 130'd0) begin n_bad++; $display("FAIL rstmid_vec: got %h want 0", FREQUENT_OUT); end
        clear_exp();
        exp_cnt[4] = 2;
        send(4'd4, 1'b0);
        send(4'd4, 1'b1);
        @(posedge CLK);
        #1;
        n_cmp++; if (FREQUENT_OUT !== exp_vec()) begin n_bad++; $display("FAIL rstmid_next_vec: got %h want %h", FREQUENT_OUT, exp_vec()); end
        // Reset while waiting for the sorter.
        n_cmp++; if (sort_begin !== 1'b1) begin n_bad++; $display("FAIL rstdone_pre_begin: got %b want 1", sort_begin); end
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        n_cmp++; if (sort_begin !== 1'b0) begin n_bad++; $display("FAIL rstdone_begin: got %b want 0", sort_begin); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstdone_busy: got %b want 0", busy); end
        n_cmp++; if (FREQUENT_OUT !== 130'd0) begin n_bad++; $display("FAIL rstdone_vec: got %h want 0", FREQUENT_OUT); end
    endtask

    initial begin
        RST       = 1'b1;
        sym_valid = 1'b0;
        SYM_IN    = 4'd0;
        sym_last  = 1'b0;
        sort_over = 1'b0;
        clear_exp();
        test_reset();
        test_basic_count();
        test_handshake_hold();
        test_saturation();
        test_illegal();
        test_single_transfer();
        test_sort_over_ignored();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
